viterbi_frame_ctrl: RTL

Frame sequencer for the convolutional-encoder / channel / Viterbi-decoder chain. It accepts payload bits from a bit source over a valid/ready handshake and drives the encoder's enable and data inputs. After the payload it appends zero tail bits to flush the encoder. It then checks decoder output against the transmitted payload to give a per-frame bit-error count. It sits between the test-pattern source and the encoder, and taps the decoder output.

---
 rtl/viterbi_frame_ctrl_if.sv | 10 +
 rtl/viterbi_frame_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_ctrl_if.sv
// Valid/ready bit-source handshake between the test-pattern source (master)
// and viterbi_frame_ctrl (slave).
interface viterbi_frame_ctrl_if;
   logic srcValid;
   logic srcData;
   logic srcReady;

   modport master (output srcValid, output srcData, input srcReady);
   modport slave  (input srcValid, input srcData, output srcReady);
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder/channel/Viterbi chain: payload load, zero tail flush,
// optional decoder bit-error count (enabled by defining VITERBI_BER_CHECK_EN).
module viterbi_frame_ctrl #(
   parameter int FRAME_LEN = 64,
   parameter int TAIL_LEN  = 2,
   parameter int DEC_LAT   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   output logic                    busy_o,
   viterbi_frame_ctrl_if.slave     src,
   output logic                    enc_enable_o,
   output logic                    enc_data_o,
   input  logic                    dec_data_i,
   output logic                    frame_done_o,
   output logic [15:0]             err_count_o,
   output logic [15:0]             frame_count_o
);

   typedef enum logic [2:0] {IDLE, LOAD, TAIL, DRAIN, DONE} state_e;

   localparam logic [31:0] LAST_BIT  = 32'(FRAME_LEN - 1);
   localparam logic [31:0] LAST_TAIL = 32'(TAIL_LEN - 1);

   state_e      state_q;
   logic [31:0] cnt_q;
   logic        busy_q;
   logic        srcReady_q;
   logic        encEnable_q;
   logic        encData_q;
   logic        frameDone_q;
   logic [15:0] frameCount_q;
   logic        handshake;

`ifdef VITERBI_BER_CHECK_EN
   localparam logic [31:0] LAST_DRAIN = 32'(DEC_LAT - 1);

   logic               encTag_q;
   logic [DEC_LAT-1:0] tagPipe_q;
   logic [DEC_LAT-1:0] bitPipe_q;
   logic [15:0]        errAcc_q;
   logic [15:0]        errCount_q;
   logic               tapError;

   assign tapError    = tagPipe_q[DEC_LAT-1] && (dec_data_i != bitPipe_q[DEC_LAT-1]);
   assign err_count_o = errCount_q;
`else
   localparam int unusedDecLat = DEC_LAT;
   logic unusedDecData;

   assign unusedDecData = dec_data_i;
   assign err_count_o   = 16'd0;
`endif

   assign handshake     = src.srcValid && srcReady_q;
   assign busy_o        = busy_q;
   assign src.srcReady  = srcReady_q;
   assign enc_enable_o  = encEnable_q;
   assign enc_data_o    = encData_q;
   assign frame_done_o  = frameDone_q;
   assign frame_count_o = frameCount_q;

   // Encoder strobes and frame_done default low each cycle; states re-assert them as needed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         srcReady_q   <= 1'b0;
         encEnable_q  <= 1'b0;
         encData_q    <= 1'b0;
         frameDone_q  <= 1'b0;
         frameCount_q <= '0;
`ifdef VITERBI_BER_CHECK_EN
         encTag_q     <= 1'b0;
         tagPipe_q    <= '0;
         bitPipe_q    <= '0;
         errAcc_q     <= '0;
         errCount_q   <= '0;
`endif
      end else begin
         encEnable_q <= 1'b0;
         encData_q   <= 1'b0;
         frameDone_q <= 1'b0;
`ifdef VITERBI_BER_CHECK_EN
         encTag_q     <= 1'b0;
         tagPipe_q[0] <= encEnable_q && encTag_q;
         bitPipe_q[0] <= encData_q;
         for (int k = DEC_LAT - 1; k > 0; k--) begin
            tagPipe_q[k] <= tagPipe_q[k-1];
            bitPipe_q[k] <= bitPipe_q[k-1];
         end
         if (tapError && (errAcc_q != 16'hFFFF)) begin
            errAcc_q <= errAcc_q + 16'd1;
         end
`endif
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
`ifdef VITERBI_BER_CHECK_EN
               errAcc_q <= '0;
`endif
               if (start_i) begin
                  state_q    <= LOAD;
                  busy_q     <= 1'b1;
                  srcReady_q <= 1'b1;
               end
            end
            LOAD: begin
               if (handshake) begin
                  encEnable_q <= 1'b1;
                  encData_q   <= src.srcData;
`ifdef VITERBI_BER_CHECK_EN
                  encTag_q    <= 1'b1;
`endif
                  if (cnt_q == LAST_BIT) begin
                     state_q    <= TAIL;
                     srcReady_q <= 1'b0;
                     cnt_q      <= '0;
                  end else begin
                     cnt_q <= cnt_q + 32'd1;
                  end
               end
            end
            TAIL: begin
               encEnable_q <= 1'b1;
               encData_q   <= 1'b0;
               if (cnt_q == LAST_TAIL) begin
                  cnt_q <= '0;
`ifdef VITERBI_BER_CHECK_EN
                  state_q <= DRAIN;
`else
                  state_q     <= DONE;
                  frameDone_q <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
`ifdef VITERBI_BER_CHECK_EN
            // The last payload bit reaches the compare tap before this wait expires.
            DRAIN: begin
               if (cnt_q == LAST_DRAIN) begin
                  cnt_q       <= '0;
                  state_q     <= DONE;
                  frameDone_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
`endif
            DONE: begin
               state_q      <= IDLE;
               busy_q       <= 1'b0;
               frameCount_q <= frameCount_q + 16'd1;
`ifdef VITERBI_BER_CHECK_EN
               errCount_q   <= errAcc_q;
`endif
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
